// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the I/D-cache memory bus arbiter: bus commands, owners,
// FSM states, memory tags and the debug snapshot struct.
package mem_bus_arbiter_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } BUS_COMMAND;

  typedef enum logic {
    IC = 1'b0,
    DC = 1'b1
  } ARB_OWNER;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } ARB_STATE;

  typedef logic [3:0] MEM_TAG;

  typedef struct packed {
    ARB_STATE state;
    MEM_TAG   outstanding;
  } arb_dbg_t;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Cache-side and memory-side signals of the arbiter. The master modport is the
// arbiter itself; the slave modport is the caches plus the memory model.
interface mem_bus_arbiter_if;
  import mem_bus_arbiter_pkg::*;

  // Handshake: a requester raises X_req with stable address/data and holds them
  // until the cycle X_ack is high; X_ack is high exactly when X is granted and
  // memory answers with a nonzero tag on mem2proc_response in that same cycle.
  logic              ic_req;
  logic [XLEN-1:0]   ic_addr;
  logic              dc_req;
  BUS_COMMAND        dc_cmd;
  logic [XLEN-1:0]   dc_addr;
  logic [63:0]       dc_data;
  logic              ic_ack;
  logic              dc_ack;
  logic              ic_rdata_valid;
  logic              dc_rdata_valid;
  logic [63:0]       rdata;
  BUS_COMMAND        proc2mem_command;
  logic [XLEN-1:0]   proc2mem_addr;
  logic [63:0]       proc2mem_data;
  MEM_TAG            mem2proc_response;
  logic [63:0]       mem2proc_data;
  MEM_TAG            mem2proc_tag;
  logic              tag_err;

  modport master (
    input  ic_req, ic_addr, dc_req, dc_cmd, dc_addr, dc_data,
    input  mem2proc_response, mem2proc_data, mem2proc_tag,
    output ic_ack, dc_ack, ic_rdata_valid, dc_rdata_valid, rdata,
    output proc2mem_command, proc2mem_addr, proc2mem_data, tag_err
  );

  modport slave (
    output ic_req, ic_addr, dc_req, dc_cmd, dc_addr, dc_data,
    output mem2proc_response, mem2proc_data, mem2proc_tag,
    input  ic_ack, dc_ack, ic_rdata_valid, dc_rdata_valid, rdata,
    input  proc2mem_command, proc2mem_addr, proc2mem_data, tag_err
  );

endinterface

// File: rtl/mem_arb_tag_table.sv
// Tag -> owner table for outstanding loads, with the outstanding-load counter.
// Returns read the pre-update owner, so a same-cycle reallocation wins the state.
module mem_arb_tag_table
  import mem_bus_arbiter_pkg::*;
#(
  parameter int N_TAGS = 16
) (
  input  logic     clock,
  input  logic     reset,
  input  logic     alloc_en,
  input  MEM_TAG   alloc_tag,
  input  ARB_OWNER alloc_owner,
  input  MEM_TAG   ret_tag,
  output logic     ret_hit,
  output ARB_OWNER ret_owner,
  output logic     full,
  output MEM_TAG   count
);

  logic [N_TAGS-1:0] valid_q;
  ARB_OWNER          owner_q [N_TAGS];
  MEM_TAG            count_q;

  assign ret_hit   = (ret_tag != MEM_TAG'(0)) && valid_q[ret_tag];
  assign ret_owner = owner_q[ret_tag];
  assign full      = (count_q == MEM_TAG'(N_TAGS - 1));
  assign count     = count_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      count_q <= '0;
      for (int i = 0; i < N_TAGS; i++) owner_q[i] <= DC;
    end else begin
      if (ret_hit) valid_q[ret_tag] <= 1'b0;
      // Allocation is written last so it overrides a same-tag return.
      if (alloc_en) begin
        valid_q[alloc_tag] <= 1'b1;
        owner_q[alloc_tag] <= alloc_owner;
      end
      case ({alloc_en, ret_hit})
        2'b10:   count_q <= count_q + MEM_TAG'(1);
        2'b01:   count_q <= count_q - MEM_TAG'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates I-cache and D-cache requests onto one memory bus and routes tagged
// load returns back to their owner. Define MEM_ARB_ROUND_ROBIN_EN for round-robin
// conflict resolution; otherwise the D-cache has fixed priority.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int N_TAGS = 16
) (
  input  logic               clock,
  input  logic               reset,
  mem_bus_arbiter_if.master  bus,
  output arb_dbg_t           dbg
);

  ARB_STATE   state_q;
  ARB_OWNER   lock_q;
  logic       tag_err_q;
  logic       grant_vld;
  ARB_OWNER   grant_own;
  BUS_COMMAND grant_cmd;
  logic       resp_nz, accept, alloc_en;
  logic       full, ret_hit;
  ARB_OWNER   ret_owner;
  MEM_TAG     count;
  logic       ic_elig, dc_elig;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  ARB_OWNER   rr_ptr_q;
`endif

  // Only loads consume a tag, so a full table still lets stores through.
  assign ic_elig   = bus.ic_req && !full;
  assign dc_elig   = bus.dc_req && !(bus.dc_cmd == BUS_LOAD && full);
  assign resp_nz   = (bus.mem2proc_response != MEM_TAG'(0));
  assign grant_cmd = (grant_own == IC) ? BUS_LOAD : bus.dc_cmd;
  assign accept    = grant_vld && resp_nz;
  assign alloc_en  = accept && (grant_cmd == BUS_LOAD);

  always_comb begin
    grant_vld = 1'b0;
    grant_own = DC;
    if (reset) begin
      if (state_q == HOLD) begin
        grant_own = lock_q;
        grant_vld = (lock_q == IC) ? bus.ic_req : bus.dc_req;
      end else if (ic_elig && dc_elig) begin
        grant_vld = 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        grant_own = rr_ptr_q;
`else
        grant_own = DC;
`endif
      end else if (dc_elig) begin
        grant_vld = 1'b1;
        grant_own = DC;
      end else if (ic_elig) begin
        grant_vld = 1'b1;
        grant_own = IC;
      end
    end
  end

  always_comb begin
    bus.proc2mem_command = BUS_NONE;
    bus.proc2mem_addr    = '0;
    bus.proc2mem_data    = '0;
    if (grant_vld) begin
      bus.proc2mem_command = grant_cmd;
      if (grant_own == IC) begin
        bus.proc2mem_addr = bus.ic_addr;
      end else begin
        bus.proc2mem_addr = bus.dc_addr;
        bus.proc2mem_data = bus.dc_data;
      end
    end
  end

  assign bus.ic_ack         = accept && (grant_own == IC);
  assign bus.dc_ack         = accept && (grant_own == DC);
  assign bus.ic_rdata_valid = ret_hit && (ret_owner == IC);
  assign bus.dc_rdata_valid = ret_hit && (ret_owner == DC);
  assign bus.rdata          = ret_hit ? bus.mem2proc_data : 64'd0;
  assign bus.tag_err        = tag_err_q;
  assign dbg                = '{state: state_q, outstanding: count};

  mem_arb_tag_table #(.N_TAGS(N_TAGS)) u_tag_table (
    .clock       (clock),
    .reset       (reset),
    .alloc_en    (alloc_en),
    .alloc_tag   (bus.mem2proc_response),
    .alloc_owner (grant_own),
    .ret_tag     (bus.mem2proc_tag),
    .ret_hit     (ret_hit),
    .ret_owner   (ret_owner),
    .full        (full),
    .count       (count)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      lock_q    <= DC;
      tag_err_q <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      rr_ptr_q  <= DC;
`endif
    end else begin
      if (bus.mem2proc_tag != MEM_TAG'(0) && !ret_hit) tag_err_q <= 1'b1;
      case (state_q)
        IDLE: if (grant_vld && !resp_nz) begin
          state_q <= HOLD;
          lock_q  <= grant_own;
        end
        // Leave on the locked requester's ack, or as soon as it withdraws.
        HOLD: if (!grant_vld || resp_nz) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
`ifdef MEM_ARB_ROUND_ROBIN_EN
      if (accept) rr_ptr_q <= (grant_own == DC) ? IC : DC;
`endif
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: inputs change on the falling edge and
// outputs are checked 1 time unit later, well clear of the rising edge.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  logic     clock = 1'b0;
  logic     reset;
  arb_dbg_t dbg;
  int       n_checks = 0;
  int       n_fail   = 0;

  mem_bus_arbiter_if bus();

  mem_bus_arbiter #(.N_TAGS(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus),
    .dbg   (dbg)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    bus.ic_req            = 1'b0;
    bus.ic_addr           = '0;
    bus.dc_req            = 1'b0;
    bus.dc_cmd            = BUS_NONE;
    bus.dc_addr           = '0;
    bus.dc_data           = '0;
    bus.mem2proc_response = '0;
    bus.mem2proc_data     = '0;
    bus.mem2proc_tag      = '0;
  endtask

  task automatic dc_load(input logic [31:0] addr);
    bus.dc_req  = 1'b1;
    bus.dc_cmd  = BUS_LOAD;
    bus.dc_addr = addr;
  endtask

  task automatic ic_load(input logic [31:0] addr);
    bus.ic_req  = 1'b1;
    bus.ic_addr = addr;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset asserted with requests pending: every output must be quiet.
    reset = 1'b0;
    drive_idle();
    ic_load(32'h100);
    dc_load(32'h200);
    bus.mem2proc_response = 4'd3;
    #1;
    chk("rst_cmd",     64'(bus.proc2mem_command), 64'(BUS_NONE));
    chk("rst_addr",    64'(bus.proc2mem_addr), 64'd0);
    chk("rst_dc_ack",  64'(bus.dc_ack), 64'd0);
    chk("rst_ic_ack",  64'(bus.ic_ack), 64'd0);
    chk("rst_tag_err", 64'(bus.tag_err), 64'd0);
    chk("rst_count",   64'(dbg.outstanding), 64'd0);

    @(negedge clock);
    reset = 1'b1;
    #1;
    // Both load together, response 3: DC wins under either policy.
    chk("both_dc_ack", 64'(bus.dc_ack), 64'd1);
    chk("both_ic_ack", 64'(bus.ic_ack), 64'd0);
    chk("both_cmd",    64'(bus.proc2mem_command), 64'(BUS_LOAD));
    chk("both_addr",   64'(bus.proc2mem_addr), 64'h200);

    @(negedge clock);
    drive_idle();
    bus.mem2proc_tag  = 4'd3;
    bus.mem2proc_data = 64'hDEAD_BEEF_1234_5678;
    #1;
    chk("ret3_count",  64'(dbg.outstanding), 64'd1);
    chk("ret3_dc_rv",  64'(bus.dc_rdata_valid), 64'd1);
    chk("ret3_ic_rv",  64'(bus.ic_rdata_valid), 64'd0);
    chk("ret3_rdata",  bus.rdata, 64'hDEAD_BEEF_1234_5678);

    // IC granted with response 0 for two cycles; DC arrives but IC stays locked.
    @(negedge clock);
    drive_idle();
    ic_load(32'h140);
    #1;
    chk("hold0_count", 64'(dbg.outstanding), 64'd0);
    chk("hold0_addr",  64'(bus.proc2mem_addr), 64'h140);
    chk("hold0_ic_ack", 64'(bus.ic_ack), 64'd0);
    @(negedge clock);
    dc_load(32'h300);
    #1;
    chk("hold1_state", 64'(dbg.state), 64'(HOLD));
    chk("hold1_addr",  64'(bus.proc2mem_addr), 64'h140);
    chk("hold1_dc_ack", 64'(bus.dc_ack), 64'd0);
    @(negedge clock);
    bus.mem2proc_response = 4'd4;
    #1;
    chk("hold2_ic_ack", 64'(bus.ic_ack), 64'd1);
    chk("hold2_dc_ack", 64'(bus.dc_ack), 64'd0);
    @(negedge clock);
    bus.ic_req = 1'b0;
    bus.mem2proc_response = 4'd5;
    #1;
    chk("after_hold_state", 64'(dbg.state), 64'(IDLE));
    chk("after_hold_dc_ack", 64'(bus.dc_ack), 64'd1);
    chk("after_hold_addr", 64'(bus.proc2mem_addr), 64'h300);

    @(negedge clock);
    drive_idle();
    bus.mem2proc_tag  = 4'd4;
    bus.mem2proc_data = 64'h0000_0000_AAAA_0004;
    #1;
    chk("ret4_count",  64'(dbg.outstanding), 64'd2);
    chk("ret4_ic_rv",  64'(bus.ic_rdata_valid), 64'd1);
    chk("ret4_dc_rv",  64'(bus.dc_rdata_valid), 64'd0);
    chk("ret4_rdata",  bus.rdata, 64'h0000_0000_AAAA_0004);
    @(negedge clock);
    bus.mem2proc_tag  = 4'd5;
    bus.mem2proc_data = 64'h5555_0000_0000_0005;
    #1;
    chk("ret5_dc_rv",  64'(bus.dc_rdata_valid), 64'd1);
    chk("ret5_rdata",  bus.rdata, 64'h5555_0000_0000_0005);

    // Locked requester withdraws in HOLD: no grant that cycle, then DC is served.
    @(negedge clock);
    drive_idle();
    ic_load(32'h180);
    #1;
    chk("drop0_count", 64'(dbg.outstanding), 64'd0);
    @(negedge clock);
    bus.ic_req = 1'b0;
    dc_load(32'h340);
    bus.mem2proc_response = 4'd6;
    #1;
    chk("drop1_state", 64'(dbg.state), 64'(HOLD));
    chk("drop1_cmd",   64'(bus.proc2mem_command), 64'(BUS_NONE));
    chk("drop1_dc_ack", 64'(bus.dc_ack), 64'd0);
    @(negedge clock);
    #1;
    chk("drop2_state", 64'(dbg.state), 64'(IDLE));
    chk("drop2_dc_ack", 64'(bus.dc_ack), 64'd1);

    // Tag 6 returns to DC while being reallocated to IC in the same cycle.
    @(negedge clock);
    drive_idle();
    ic_load(32'h1C0);
    bus.mem2proc_response = 4'd6;
    bus.mem2proc_tag      = 4'd6;
    bus.mem2proc_data     = 64'h6666_0000_0000_00DC;
    #1;
    chk("same_count_before", 64'(dbg.outstanding), 64'd1);
    chk("same_dc_rv",  64'(bus.dc_rdata_valid), 64'd1);
    chk("same_ic_rv",  64'(bus.ic_rdata_valid), 64'd0);
    chk("same_ic_ack", 64'(bus.ic_ack), 64'd1);
    @(negedge clock);
    drive_idle();
    bus.mem2proc_tag  = 4'd6;
    bus.mem2proc_data = 64'h6666_0000_0000_001C;
    #1;
    chk("same_count_after", 64'(dbg.outstanding), 64'd1);
    chk("same2_ic_rv", 64'(bus.ic_rdata_valid), 64'd1);
    chk("same2_dc_rv", 64'(bus.dc_rdata_valid), 64'd0);

    // Fill to 15 outstanding loads.
    for (int i = 1; i <= 15; i++) begin
      @(negedge clock);
      drive_idle();
      dc_load(32'h1000 + 32'(i) * 32'd8);
      bus.mem2proc_response = MEM_TAG'(i);
      #1;
      chk($sformatf("fill%0d_dc_ack", i), 64'(bus.dc_ack), 64'd1);
    end
    @(negedge clock);
    bus.mem2proc_response = 4'd1;
    ic_load(32'h2000);
    #1;
    chk("full_count",  64'(dbg.outstanding), 64'd15);
    chk("full_dc_ack", 64'(bus.dc_ack), 64'd0);
    chk("full_ic_ack", 64'(bus.ic_ack), 64'd0);
    chk("full_cmd",    64'(bus.proc2mem_command), 64'(BUS_NONE));
    @(negedge clock);
    bus.dc_cmd  = BUS_STORE;
    bus.dc_data = 64'h0123_4567_89AB_CDEF;
    bus.mem2proc_response = 4'd2;
    #1;
    chk("store_dc_ack", 64'(bus.dc_ack), 64'd1);
    chk("store_cmd",    64'(bus.proc2mem_command), 64'(BUS_STORE));
    chk("store_data",   bus.proc2mem_data, 64'h0123_4567_89AB_CDEF);
    @(negedge clock);
    bus.dc_req = 1'b0;
    bus.mem2proc_response = 4'd0;
    bus.mem2proc_tag  = 4'd9;
    bus.mem2proc_data = 64'h9999;
    #1;
    chk("store_count", 64'(dbg.outstanding), 64'd15);
    chk("ret9_dc_rv",  64'(bus.dc_rdata_valid), 64'd1);
    chk("ret9_ic_ack", 64'(bus.ic_ack), 64'd0);
    @(negedge clock);
    bus.mem2proc_tag = 4'd0;
    bus.mem2proc_response = 4'd9;
    #1;
    chk("unfull_count",  64'(dbg.outstanding), 64'd14);
    chk("unfull_ic_ack", 64'(bus.ic_ack), 64'd1);

    // Reset, build 4 outstanding, enter HOLD, then reset mid-cycle.
    @(negedge clock);
    drive_idle();
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("rst2_count", 64'(dbg.outstanding), 64'd0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clock);
      dc_load(32'h3000 + 32'(i) * 32'd8);
      bus.mem2proc_response = MEM_TAG'(i);
      #1;
    end
    @(negedge clock);
    drive_idle();
    ic_load(32'h4000);
    @(negedge clock);
    #1;
    chk("mid_state", 64'(dbg.state), 64'(HOLD));
    chk("mid_count", 64'(dbg.outstanding), 64'd4);
    chk("mid_cmd",   64'(bus.proc2mem_command), 64'(BUS_LOAD));
    #1;
    reset = 1'b0;
    #1;
    chk("midrst_state", 64'(dbg.state), 64'(IDLE));
    chk("midrst_count", 64'(dbg.outstanding), 64'd0);
    chk("midrst_cmd",   64'(bus.proc2mem_command), 64'(BUS_NONE));
    chk("midrst_addr",  64'(bus.proc2mem_addr), 64'd0);
    @(negedge clock);
    drive_idle();
    reset = 1'b1;

    // A tag issued before reset comes back: it is now orphaned.
    bus.mem2proc_tag  = 4'd3;
    bus.mem2proc_data = 64'h3333;
    #1;
    chk("stale_dc_rv", 64'(bus.dc_rdata_valid), 64'd0);
    @(negedge clock);
    bus.mem2proc_tag = 4'd0;
    #1;
    chk("stale_tag_err", 64'(bus.tag_err), 64'd1);
    reset = 1'b0;
    #1;
    chk("err_cleared", 64'(bus.tag_err), 64'd0);
    @(negedge clock);
    reset = 1'b1;

    // Unknown tag 5: data dropped, tag_err sticks until reset.
    bus.mem2proc_tag  = 4'd5;
    bus.mem2proc_data = 64'h5005;
    #1;
    chk("orph_dc_rv",  64'(bus.dc_rdata_valid), 64'd0);
    chk("orph_ic_rv",  64'(bus.ic_rdata_valid), 64'd0);
    chk("orph_rdata",  bus.rdata, 64'd0);
    @(negedge clock);
    bus.mem2proc_tag = 4'd0;
    repeat (3) @(negedge clock);
    #1;
    chk("orph_sticky", 64'(bus.tag_err), 64'd1);
    reset = 1'b0;
    #1;
    chk("orph_reset", 64'(bus.tag_err), 64'd0);
    @(negedge clock);
    reset = 1'b1;

    // Continuous contention, every request accepted immediately.
    for (int i = 1; i <= 4; i++) begin
      @(negedge clock);
      ic_load(32'h5000);
      dc_load(32'h6000);
      bus.mem2proc_response = MEM_TAG'(i);
      #1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      chk($sformatf("rr%0d_dc_ack", i), 64'(bus.dc_ack), (i % 2 == 1) ? 64'd1 : 64'd0);
      chk($sformatf("rr%0d_ic_ack", i), 64'(bus.ic_ack), (i % 2 == 1) ? 64'd0 : 64'd1);
`else
      chk($sformatf("fix%0d_dc_ack", i), 64'(bus.dc_ack), 64'd1);
      chk($sformatf("fix%0d_ic_ack", i), 64'(bus.ic_ack), 64'd0);
`endif
    end
    @(negedge clock);
    drive_idle();
    #1;
    chk("final_count", 64'(dbg.outstanding), 64'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
